// File: rtl/ips2l_pcie_dma_req_split.sv
// Splits one DMA command into MWr/MRd requests bounded by MPS/MRRS and 4KB pages,
// choosing 32- or 64-bit request form for each chunk.
module ips2l_pcie_dma_req_split #(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           i_cfg_max_payload_size,
  input  logic [2:0]           i_cfg_max_rd_req_size,
  input  logic                 i_cmd_vld,
  output logic                 o_cmd_rdy,
  input  logic                 i_cmd_wr,
  input  logic [63:0]          i_cmd_addr,
  input  logic [LEN_WIDTH-1:0] i_cmd_len,
  output logic                 o_mwr32_req,
  output logic                 o_mwr64_req,
  input  logic                 i_mwr32_req_ack,
  input  logic                 i_mwr64_req_ack,
  output logic                 o_mrd32_req,
  output logic                 o_mrd64_req,
  input  logic                 i_mrd32_req_ack,
  input  logic                 i_mrd64_req_ack,
  output logic [9:0]           o_req_length,
  output logic [63:0]          o_req_addr,
  input  logic                 i_tag_full,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int CW = (LEN_WIDTH > 11) ? LEN_WIDTH : 11;

  typedef enum logic [1:0] {IDLE, CALC, REQ, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 dir_wr;
  logic                 is64;
  logic [63:0]          addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [LEN_WIDTH-1:0] rem_after;
  logic [10:0]          chunk;
  logic [10:0]          chunk_calc;
  logic [10:0]          bnd_dw;
  logic                 ack_hit;

  function automatic logic [10:0] max_dw(input logic [2:0] code);
    return (code >= 3'd5) ? 11'd1024 : (11'd32 << code);
  endfunction

  function automatic logic [CW-1:0] min2(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Distance to the next 4KB page in DW; always 1..1024 since addr is DW aligned.
  always_comb begin
    logic [CW-1:0] tmp;
    bnd_dw     = 11'd1024 - {1'b0, addr[11:2]};
    tmp        = min2(CW'(remaining),
                      CW'(max_dw(dir_wr ? i_cfg_max_payload_size : i_cfg_max_rd_req_size)));
    tmp        = min2(tmp, CW'(bnd_dw));
    chunk_calc = tmp[10:0];
  end

  assign rem_after = remaining - LEN_WIDTH'(chunk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_cmd_rdy   = (state == IDLE);
    o_busy      = (state != IDLE);
    o_done      = (state == DONE);
    o_mwr32_req = (state == REQ) &  dir_wr & ~is64;
    o_mwr64_req = (state == REQ) &  dir_wr &  is64;
    o_mrd32_req = (state == REQ) & ~dir_wr & ~is64 & ~i_tag_full;
    o_mrd64_req = (state == REQ) & ~dir_wr &  is64 & ~i_tag_full;
    ack_hit     = (o_mwr32_req & i_mwr32_req_ack) | (o_mwr64_req & i_mwr64_req_ack) |
                  (o_mrd32_req & i_mrd32_req_ack) | (o_mrd64_req & i_mrd64_req_ack);
    case (state)
      IDLE: if (i_cmd_vld) state_nxt = (i_cmd_len == '0) ? DONE : CALC;
      CALC: state_nxt = REQ;
      REQ:  if (ack_hit) state_nxt = (rem_after == '0) ? DONE : CALC;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_wr       <= 1'b0;
      is64         <= 1'b0;
      addr         <= '0;
      remaining    <= '0;
      chunk        <= '0;
      o_req_addr   <= '0;
      o_req_length <= '0;
    end else begin
      case (state)
        IDLE: if (i_cmd_vld) begin
          dir_wr    <= i_cmd_wr;
          addr      <= {i_cmd_addr[63:2], 2'b00};
          remaining <= i_cmd_len;
        end
        CALC: begin
          chunk        <= chunk_calc;
          is64         <= |addr[63:32];
          o_req_addr   <= addr;
          o_req_length <= chunk_calc[9:0];
        end
        REQ: if (ack_hit) begin
          addr      <= addr + {51'd0, chunk, 2'b00};
          remaining <= rem_after;
        end
        default: ;
      endcase
    end
  end

endmodule
